// File: rtl/tx_code_group_gen_pkg.sv
// Shared encodings and code-group constants for the 1000BASE-X
// transmit code-group generator.
package tx_code_group_gen_pkg;

    localparam logic [2:0] OS_D = 3'd0;
    localparam logic [2:0] OS_I = 3'd1;
    localparam logic [2:0] OS_S = 3'd2;
    localparam logic [2:0] OS_T = 3'd3;
    localparam logic [2:0] OS_R = 3'd4;
    localparam logic [2:0] OS_V = 3'd5;

    typedef enum logic [1:0] {
        ST_GEN = 2'd0,
        ST_I1B = 2'd1,
        ST_I2B = 2'd2
    } state_e;

    // Octet values fed to the encoder for each special code group
    localparam logic [7:0] OCT_K28_5 = 8'hBC;
    localparam logic [7:0] OCT_K27_7 = 8'hFB;
    localparam logic [7:0] OCT_K29_7 = 8'hFD;
    localparam logic [7:0] OCT_K23_7 = 8'hF7;
    localparam logic [7:0] OCT_K30_7 = 8'hFE;
    localparam logic [7:0] OCT_D5_6  = 8'hC5;
    localparam logic [7:0] OCT_D16_2 = 8'h50;

    localparam logic [9:0] K28_5_N = 10'h0FA;
    localparam logic [9:0] K28_5_P = 10'h305;
    localparam logic [9:0] K27_7_N = 10'h368;
    localparam logic [9:0] K27_7_P = 10'h097;
    localparam logic [9:0] K29_7_N = 10'h2E8;
    localparam logic [9:0] K29_7_P = 10'h117;
    localparam logic [9:0] K23_7_N = 10'h3A8;
    localparam logic [9:0] K23_7_P = 10'h057;
    localparam logic [9:0] K30_7_N = 10'h1E8;
    localparam logic [9:0] K30_7_P = 10'h217;
    localparam logic [9:0] D5_6_N  = 10'h296;
    localparam logic [9:0] D5_6_P  = 10'h296;
    localparam logic [9:0] D16_2_N = 10'h1B5;
    localparam logic [9:0] D16_2_P = 10'h245;

endpackage

// File: rtl/tx_code_group_gen_encoder.sv
// Combinational 8B/10B encoder; 6b and 4b sub-blocks each
// update running disparity in turn.
module encoder_8b10b (
    input  logic [7:0] octet,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out
);

    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] six_n, six;
    logic [3:0] four_n, four;
    logic       k28, flip6, rd6, alt7, flip4;

    assign x = octet[4:0];
    assign y = octet[7:5];

    always_comb begin
        six_n = 6'b000000;
        unique case (x)
            5'd0:  six_n = 6'b100111;
            5'd1:  six_n = 6'b011101;
            5'd2:  six_n = 6'b101101;
            5'd3:  six_n = 6'b110001;
            5'd4:  six_n = 6'b110101;
            5'd5:  six_n = 6'b101001;
            5'd6:  six_n = 6'b011001;
            5'd7:  six_n = 6'b111000;
            5'd8:  six_n = 6'b111001;
            5'd9:  six_n = 6'b100101;
            5'd10: six_n = 6'b010101;
            5'd11: six_n = 6'b110100;
            5'd12: six_n = 6'b001101;
            5'd13: six_n = 6'b101100;
            5'd14: six_n = 6'b011100;
            5'd15: six_n = 6'b010111;
            5'd16: six_n = 6'b011011;
            5'd17: six_n = 6'b100011;
            5'd18: six_n = 6'b010011;
            5'd19: six_n = 6'b110010;
            5'd20: six_n = 6'b001011;
            5'd21: six_n = 6'b101010;
            5'd22: six_n = 6'b011010;
            5'd23: six_n = 6'b111010;
            5'd24: six_n = 6'b110011;
            5'd25: six_n = 6'b100110;
            5'd26: six_n = 6'b010110;
            5'd27: six_n = 6'b110110;
            5'd28: six_n = 6'b001110;
            5'd29: six_n = 6'b101110;
            5'd30: six_n = 6'b011110;
            5'd31: six_n = 6'b101011;
        endcase
        k28 = is_k && (x == 5'd28);
        if (k28) six_n = 6'b001111;
        // D.7 is balanced yet still has a distinct RD+ form
        flip6 = ($countones(six_n) != 3) || ((x == 5'd7) && !k28);
        six = (rd_in && flip6) ? ~six_n : six_n;
        rd6 = ($countones(six) == 3) ? rd_in : ($countones(six) > 3);

        alt7 = (y == 3'd7) && (is_k ||
               (!rd6 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
               (rd6 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        four_n = 4'b0000;
        unique case (y)
            3'd0: four_n = 4'b1011;
            3'd1: four_n = 4'b1001;
            3'd2: four_n = 4'b0101;
            3'd3: four_n = 4'b1100;
            3'd4: four_n = 4'b1101;
            3'd5: four_n = 4'b1010;
            3'd6: four_n = 4'b0110;
            3'd7: four_n = alt7 ? 4'b0111 : 4'b1110;
        endcase
        flip4 = ($countones(four_n) != 2) || (y == 3'd3);
        four = (rd6 && flip4) ? ~four_n : four_n;
        // K28.y balanced tails are inverted relative to data
        if (k28 && !flip4) four = rd6 ? four_n : ~four_n;
        rd_out = ($countones(four) == 2) ? rd6 : ($countones(four) > 2);
        code = {six, four};
    end

endmodule

// File: rtl/tx_code_group_gen.sv
// Transmit code-group FSM: maps ordered sets to one code group
// per clock with registered outputs and running disparity.
module tx_code_group_gen
    import tx_code_group_gen_pkg::*;
(
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [2:0] tx_o_set,
    input  logic [7:0] TXD,
    output logic [9:0] tx_code_group,
    output logic       tx_even,
    output logic       TX_OSET_indicate,
    output logic       tx_disparity
);

    state_e     state_q, state_d;
    logic [9:0] code_q, code_d;
    logic       even_q, even_d;
    logic       ind_q, ind_d;
    logic       rd_q, rd_d;
    logic [7:0] octet;
    logic       is_k;

    encoder_8b10b u_enc (
        .octet  (octet),
        .is_k   (is_k),
        .rd_in  (rd_q),
        .code   (code_d),
        .rd_out (rd_d)
    );

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_q <= ST_GEN;
            code_q  <= 10'h000;
            even_q  <= 1'b0;
            ind_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            even_q  <= even_d;
            ind_q   <= ind_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = ST_GEN;
        unique case (state_q)
            ST_GEN: begin
                if (tx_o_set == OS_I)
                    state_d = rd_q ? ST_I1B : ST_I2B;
            end
            ST_I1B:  state_d = ST_GEN;
            ST_I2B:  state_d = ST_GEN;
            default: state_d = ST_GEN;
        endcase
    end

    always_comb begin
        octet  = OCT_K30_7;
        is_k   = 1'b1;
        even_d = ~even_q;
        ind_d  = 1'b1;
        unique case (state_q)
            ST_GEN: begin
                unique case (tx_o_set)
                    OS_D: begin
                        octet = TXD;
                        is_k  = 1'b0;
                    end
                    OS_I: begin
                        octet  = OCT_K28_5;
                        even_d = 1'b1;
                        ind_d  = 1'b0;
                    end
                    OS_S:    octet = OCT_K27_7;
                    OS_T:    octet = OCT_K29_7;
                    OS_R:    octet = OCT_K23_7;
                    default: octet = OCT_K30_7;
                endcase
            end
            ST_I1B: begin
                octet  = OCT_D5_6;
                is_k   = 1'b0;
                even_d = 1'b0;
            end
            ST_I2B: begin
                octet  = OCT_D16_2;
                is_k   = 1'b0;
                even_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign tx_code_group    = code_q;
    assign tx_even          = even_q;
    assign TX_OSET_indicate = ind_q;
    assign tx_disparity     = rd_q;

endmodule

// File: tb/tb_tx_code_group_gen.sv
// Scoreboard bench for tx_code_group_gen; expected words are
// {code[9:0], even, indicate, disparity}.
module tb_tx_code_group_gen;

    logic       clk;
    logic       mr_main_reset;
    logic [2:0] tx_o_set;
    logic [7:0] TXD;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       TX_OSET_indicate;
    logic       tx_disparity;

    int          n_checks;
    int          n_fail;
    logic [12:0] sb[$];
    logic [12:0] obs;
    logic [12:0] exp_v;

    tx_code_group_gen dut (
        .GTX_CLK          (clk),
        .mr_main_reset    (mr_main_reset),
        .tx_o_set         (tx_o_set),
        .TXD              (TXD),
        .tx_code_group    (tx_code_group),
        .tx_even          (tx_even),
        .TX_OSET_indicate (TX_OSET_indicate),
        .tx_disparity     (tx_disparity)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #3 mr_main_reset = 1'b0;
        #1;
        obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_async got %h want %h", obs, 13'h0);
        end
        @(posedge clk); #1;
        obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_held got %h want %h", obs, 13'h0);
        end
    endtask

    task automatic test_idle();
        logic [2:0]  os [4];
        logic [12:0] ex [4];
        os = '{3'd1, 3'd2, 3'd1, 3'd1};
        ex = '{{10'h0FA, 3'b101}, {10'h245, 3'b010},
               {10'h0FA, 3'b101}, {10'h245, 3'b010}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mr_main_reset = 1'b1;
            tx_o_set = os[i];
            TXD = 8'h00;
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL idle[%0d] got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_data();
        @(negedge clk);
        tx_o_set = 3'd0;
        TXD = 8'h00;
        sb.push_back({10'h274, 3'b110});
        @(posedge clk); #1;
        obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
        exp_v = sb.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL data_d0 got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  os [9];
        logic [7:0]  dt [9];
        logic [12:0] ex [9];
        os = '{3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd4, 3'd1, 3'd0};
        dt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h43,
               8'h00, 8'h00, 8'h00, 8'hFF};
        ex = '{{10'h368, 3'b010}, {10'h1D4, 3'b110},
               {10'h2D4, 3'b010}, {10'h31B, 3'b111},
               {10'h315, 3'b011}, {10'h117, 3'b111},
               {10'h057, 3'b011}, {10'h305, 3'b100},
               {10'h296, 3'b010}};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tx_o_set = os[i];
            TXD = dt[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_rdplus_idle();
        logic [2:0]  os [3];
        logic [7:0]  dt [3];
        logic [12:0] ex [3];
        os = '{3'd0, 3'd1, 3'd5};
        dt = '{8'h03, 8'h00, 8'h00};
        ex = '{{10'h31B, 3'b111}, {10'h305, 3'b100}, {10'h296, 3'b010}};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_o_set = os[i];
            TXD = dt[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rdplus[%0d] got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_invalid_oset();
        logic [2:0]  os [7];
        logic [7:0]  dt [7];
        logic [12:0] ex [7];
        os = '{3'd7, 3'd6, 3'd5, 3'd0, 3'd5, 3'd1, 3'd7};
        dt = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00};
        ex = '{{10'h1E8, 3'b110}, {10'h1E8, 3'b010},
               {10'h1E8, 3'b110}, {10'h31B, 3'b011},
               {10'h217, 3'b111}, {10'h305, 3'b100},
               {10'h296, 3'b010}};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            tx_o_set = os[i];
            TXD = dt[i];
            sb.push_back(ex[i]);
            @(posedge clk); #1;
            obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL invalid[%0d] got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_idle();
        @(negedge clk);
        tx_o_set = 3'd1;
        TXD = 8'h00;
        sb.push_back({10'h0FA, 3'b101});
        @(posedge clk); #1;
        obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
        exp_v = sb.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL mid_k285 got %h want %h", obs, exp_v);
        end
        #2 mr_main_reset = 1'b0;
        #1;
        obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_async got %h want %h", obs, 13'h0);
        end
        @(posedge clk); #1;
        obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_held got %h want %h", obs, 13'h0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mr_main_reset = 1'b1;
            tx_o_set = 3'd0;
            TXD = 8'h00;
            sb.push_back({10'h274, (i == 0) ? 3'b110 : 3'b010});
            @(posedge clk); #1;
            obs = {tx_code_group, tx_even, TX_OSET_indicate, tx_disparity};
            exp_v = sb.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL mid_release[%0d] got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        clk = 1'b0;
        mr_main_reset = 1'b1;
        tx_o_set = 3'd0;
        TXD = 8'h00;
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_idle();
        test_data();
        test_back_to_back();
        test_rdplus_idle();
        test_invalid_oset();
        test_reset_mid_idle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_code_group_gen.md
TX_CODE_GROUP_GEN -- requirements
Module: tx_code_group_gen

Interface
REQ-001 SHALL have port GTX_CLK  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port mr_main_reset  input  1  reset is asynchronous and active-low.
REQ-003 SHALL have port tx_o_set  input  3  ordered set requested by TRANSMIT: 0=/D/, 1=/I/, 2=/S/, 3=/T/, 4=/R/, 5=/V/.
REQ-004 SHALL have port TXD  input  8  data octet, used only when tx_o_set=/D/.
REQ-005 SHALL have port tx_code_group  output  10  encoded code group, bit 9=a … bit 0=j (abcdei fghj).
REQ-006 SHALL have port tx_even  output  1  high when the current code group is at an even position.
REQ-007 SHALL have port TX_OSET_indicate  output  1  high when the ordered set is complete and TRANSMIT may present the next tx_o_set.
REQ-008 SHALL have port tx_disparity  output  1  running disparity after the current code group: 0=RD-, 1=RD+.

Function
REQ-009 SHALL emit exactly one code group per GTX_CLK cycle; all outputs registered; latency from sampled tx_o_set/TXD to tx_code_group is 1 clock.
REQ-010 SHALL implement states GEN, IDLE_I1B, IDLE_I2B; tx_o_set and TXD sampled only in GEN.
REQ-011 In GEN with /D/: SHALL output ENC(TXD, D, RD), toggle tx_even, set TX_OSET_indicate=1, stay in GEN.
REQ-012 In GEN with /S/, /T/, /R/, /V/: SHALL output K27.7, K29.7, K23.7, K30.7 respectively, toggle tx_even, set TX_OSET_indicate=1, stay in GEN.
REQ-013 In GEN with /I/: SHALL output K28.5, force tx_even=1, set TX_OSET_indicate=0; next state IDLE_I1B if RD was + before K28.5, else IDLE_I2B.
REQ-014 In IDLE_I1B: SHALL output D5.6, tx_even=0, TX_OSET_indicate=1, next GEN.
REQ-015 In IDLE_I2B: SHALL output D16.2, tx_even=0, TX_OSET_indicate=1, next GEN.
REQ-016 After every /I/, running disparity SHALL be RD-.
REQ-017 Running disparity SHALL be updated per IEEE 802.3 Clause 36 8B/10B rules after every emitted code group, sub-blocks 6b and 4b evaluated separately.
REQ-018 tx_o_set/TXD changes in IDLE_I1B/IDLE_I2B SHALL be ignored.
REQ-019 tx_o_set values 6 and 7 SHALL be treated as /V/.
REQ-020 K28.5 SHALL be emitted from GEN regardless of tx_even; /I/ alignment is TRANSMIT's responsibility.

Reset
REQ-021 On mr_main_reset=0, immediately and asynchronously: state=GEN, tx_code_group=10'h000, tx_even=0, TX_OSET_indicate=0, tx_disparity=0 (RD-).
REQ-022 Reset asserted mid-/I/ (in IDLE_I1B/IDLE_I2B) SHALL abort the ordered set; no second code group after release.
REQ-023 First edge after release SHALL process tx_o_set in GEN with RD-.

Structure
REQ-024 Shared package SHALL hold tx_o_set encodings, state encodings, and 10-bit constants for K28.5, K27.7, K29.7, K23.7, K30.7, D5.6, D16.2 (both disparities).
REQ-025 8B/10B encoding SHALL be a combinational sub-module encoder_8b10b (inputs: octet, is_k, rd_in; outputs: code[9:0], rd_out); tx_code_group_gen holds only the FSM and registers.

Verification
REQ-026 Reset then tx_o_set=/I/ held: alternating 10'h0FA (K28.5-, tx_even=1, indicate=0) / 10'h245 (D16.2+, tx_even=0, indicate=1), tx_disparity 1 then 0.
REQ-027 Force RD+ (e.g. /D/ TXD=8'h03 from RD-), then /I/: 10'h305 (K28.5+) then 10'h296 (D5.6-), tx_disparity=0 after.
REQ-028 From RD-, /D/ TXD=8'h00: 10'h274, tx_disparity stays 0, tx_even toggles, indicate=1.
REQ-029 From RD-, /S/: 10'h368 (K27.7-), tx_disparity=0; then /D/ 8'h01,8'h02,8'h03,8'h43, /T/, /R/, then /I/ -- each code matches Clause 36 table, tx_even strictly alternates, /I/ starts with tx_even=1.
REQ-030 Assert mr_main_reset=0 one cycle after K28.5 in GEN-/I/: outputs go to reset values without clock edge; after release, no D5.6/D16.2 emitted.
REQ-031 tx_o_set=3'd7 from RD-: output equals /V/ (K30.7-, 10'h1E8).
